// File: rtl/wb_daq_sample_fifo.sv
// DAQ front end: decimates ADC samples, packs pairs into 32-bit words and
// buffers them in a first-word-fall-through FIFO drained by the bus master.
module wb_daq_sample_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SW         = 16
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [15:0]           decim_i,
    input  logic [DEPTH_LOG2:0]   threshold_i,
    input  logic [SW-1:0]         adc_data_i,
    input  logic                  adc_valid_i,
    input  logic                  rd_en_i,
    output logic [2*SW-1:0]       rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  data_req_o,
    output logic                  overflow_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [15:0]     dcnt_q, dcnt_d;
    logic            half_q, half_d;
    logic [SW-1:0]   lo_q, lo_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            dreq_q, dreq_d;

    logic [2*SW-1:0] mem [DEPTH];

    logic [16:0]     decim_eff;
    logic [16:0]     dcnt_inc;
    logic            accept;
    logic            push;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic [2*SW-1:0] push_word;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                        (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign rd_data_o  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign data_req_o = dreq_q;
    assign overflow_o = ovf_q;

    // A ratio of 0 behaves like 1; 17-bit compare avoids wrap at decim_i=0xFFFF.
    assign decim_eff = (decim_i == 16'd0) ? 17'd1 : {1'b0, decim_i};
    assign dcnt_inc  = {1'b0, dcnt_q} + 17'd1;
    assign accept    = adc_valid_i & enable_i & (dcnt_q == 16'd0);
    assign push      = accept & half_q;
    assign push_word = {adc_data_i, lo_q};

    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign pop     = rd_en_i & ~empty_o & ~clear_i;
    assign push_ok = push & (~full_o | pop) & ~clear_i;
    assign drop    = push & full_o & ~pop & ~clear_i;

    always_comb begin
        dcnt_d   = dcnt_q;
        half_d   = half_q;
        lo_d     = lo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        dreq_d   = (threshold_i != '0) && (level_o >= threshold_i);

        if (clear_i) begin
            dcnt_d   = '0;
            half_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (!enable_i) begin
                dcnt_d = '0;
                half_d = 1'b0;
            end else if (adc_valid_i) begin
                dcnt_d = (dcnt_inc >= decim_eff) ? 16'd0 : dcnt_inc[15:0];
                if (accept) begin
                    if (half_q) begin
                        half_d = 1'b0;
                    end else begin
                        lo_d   = adc_data_i;
                        half_d = 1'b1;
                    end
                end
            end
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (drop)    ovf_d    = 1'b1;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            dcnt_q   <= '0;
            half_q   <= 1'b0;
            lo_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            dreq_q   <= 1'b0;
        end else begin
            dcnt_q   <= dcnt_d;
            half_q   <= half_d;
            lo_q     <= lo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            dreq_q   <= dreq_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push_ok) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_word;
    end

endmodule

// File: tb/tb_wb_daq_sample_fifo.sv
// Self-checking bench for wb_daq_sample_fifo: directed test-plan steps followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_wb_daq_sample_fifo;

    localparam int DEPTH = 16;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        en;
    logic        clr;
    logic [15:0] dec;
    logic [4:0]  thr;
    logic [15:0] adcData;
    logic        valid;
    logic        rd;
    logic [31:0] rdData;
    logic        emptyO;
    logic        fullO;
    logic [4:0]  levelO;
    logic        dataReq;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [15:0] mLo;
    bit          mHalf;
    int          mIdx;
    bit          mOvf;
    bit          mDreq;

    wb_daq_sample_fifo #(.DEPTH_LOG2(4), .SW(16)) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .enable_i    (en),
        .clear_i     (clr),
        .decim_i     (dec),
        .threshold_i (thr),
        .adc_data_i  (adcData),
        .adc_valid_i (valid),
        .rd_en_i     (rd),
        .rd_data_o   (rdData),
        .empty_o     (emptyO),
        .full_o      (fullO),
        .level_o     (levelO),
        .data_req_o  (dataReq),
        .overflow_o  (overflow)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mHalf = 0;
        mIdx  = 0;
        mOvf  = 0;
        mDreq = 0;
        mLo   = '0;
    endtask

    // Reference: keep sample n (counted since enable/clear) iff n mod ratio == 0.
    task automatic modelUpdate();
        int pre;
        int eff;
        bit doPop;
        bit doPush;
        logic [31:0] w;
        pre    = mq.size();
        mDreq  = (thr != 0) && (pre >= int'(thr));
        doPush = 0;
        w      = '0;
        if (clr) begin
            mq.delete();
            mHalf = 0;
            mIdx  = 0;
            mOvf  = 0;
            return;
        end
        if (!en) begin
            mIdx  = 0;
            mHalf = 0;
        end else if (valid) begin
            eff = (dec == 0) ? 1 : int'(dec);
            if ((mIdx % eff) == 0) begin
                if (mHalf) begin
                    w      = {adcData, mLo};
                    doPush = 1;
                    mHalf  = 0;
                end else begin
                    mLo   = adcData;
                    mHalf = 1;
                end
            end
            mIdx++;
        end
        doPop = rd && (pre > 0);
        if (doPop) void'(mq.pop_front());
        if (doPush) begin
            if (pre == DEPTH && !doPop) mOvf = 1;
            else mq.push_back(w);
        end
    endtask

    task automatic compareAll();
        checkOutput("level", 32'(levelO), 32'(mq.size()));
        checkOutput("empty", 32'(emptyO), 32'(mq.size() == 0));
        checkOutput("full", 32'(fullO), 32'(mq.size() == DEPTH));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        checkOutput("data_req", 32'(dataReq), 32'(mDreq));
        if (mq.size() > 0) checkOutput("head", rdData, mq[0]);
    endtask

    task automatic tick();
        @(posedge wb_clk);
        modelUpdate();
        @(negedge wb_clk);
        compareAll();
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
        valid   = v;
        adcData = d;
        rd      = r;
        tick();
        valid = 1'b0;
        rd    = 1'b0;
    endtask

    task automatic doClear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int rdPct;
        wb_rst_n = 1'b0;
        en = 1'b1; clr = 1'b0; dec = 16'd1; thr = '0;
        adcData = '0; valid = 1'b0; rd = 1'b0;
        modelReset();
        repeat (2) @(negedge wb_clk);
        checkOutput("rst_empty", 32'(emptyO), 32'd1);
        checkOutput("rst_full", 32'(fullO), 32'd0);
        checkOutput("rst_level", 32'(levelO), 32'd0);
        checkOutput("rst_dreq", 32'(dataReq), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        wb_rst_n = 1'b1;

        // Basic packing, ratio 1
        applyStimulus(1, 16'h0001, 0);
        checkOutput("t1_empty_after1", 32'(emptyO), 32'd1);
        applyStimulus(1, 16'h0002, 0);
        checkOutput("t1_empty_after2", 32'(emptyO), 32'd0);
        applyStimulus(1, 16'h0003, 0);
        applyStimulus(1, 16'h0004, 0);
        checkOutput("t1_level", 32'(levelO), 32'd2);
        checkOutput("t1_word0", rdData, 32'h00020001);
        applyStimulus(0, 16'h0, 1);
        checkOutput("t1_word1", rdData, 32'h00040003);
        applyStimulus(0, 16'h0, 1);
        checkOutput("t1_drained", 32'(emptyO), 32'd1);
        applyStimulus(0, 16'h0, 1);

        // Decimation by 3
        doClear();
        dec = 16'd3;
        for (int i = 0; i < 12; i++) applyStimulus(1, 16'(i), 0);
        checkOutput("t2_level", 32'(levelO), 32'd2);
        checkOutput("t2_word0", rdData, 32'h00030000);
        applyStimulus(0, 16'h0, 1);
        checkOutput("t2_word1", rdData, 32'h00090006);
        applyStimulus(0, 16'h0, 1);

        // Overflow then clear
        doClear();
        dec = 16'd1;
        for (int i = 0; i < 34; i++) applyStimulus(1, 16'(16'h0100 + i), 0);
        checkOutput("t3_full", 32'(fullO), 32'd1);
        checkOutput("t3_level", 32'(levelO), 32'd16);
        checkOutput("t3_ovf", 32'(overflow), 32'd1);
        checkOutput("t3_head", rdData, 32'h01010100);
        doClear();
        checkOutput("t3_clr_level", 32'(levelO), 32'd0);
        checkOutput("t3_clr_empty", 32'(emptyO), 32'd1);
        checkOutput("t3_clr_ovf", 32'(overflow), 32'd0);

        // Push and pop together while full
        for (int i = 0; i < 32; i++) applyStimulus(1, 16'(16'h0200 + i), 0);
        applyStimulus(1, 16'h3000, 0);
        applyStimulus(1, 16'h3001, 1);
        checkOutput("t4_level", 32'(levelO), 32'd16);
        checkOutput("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 16'h0, 1);
        checkOutput("t4_last", rdData, 32'h30013000);
        applyStimulus(0, 16'h0, 1);

        // Threshold request
        doClear();
        thr = 5'd4;
        for (int i = 0; i < 8; i++) applyStimulus(1, 16'(i), 0);
        checkOutput("t5_level4", 32'(levelO), 32'd4);
        checkOutput("t5_dreq_lag", 32'(dataReq), 32'd0);
        applyStimulus(0, 16'h0, 0);
        checkOutput("t5_dreq_rise", 32'(dataReq), 32'd1);
        applyStimulus(0, 16'h0, 1);
        checkOutput("t5_dreq_hold", 32'(dataReq), 32'd1);
        applyStimulus(0, 16'h0, 0);
        checkOutput("t5_dreq_fall", 32'(dataReq), 32'd0);
        thr = 5'd0;
        doClear();
        for (int i = 0; i < 8; i++) applyStimulus(1, 16'(i), 0);
        applyStimulus(0, 16'h0, 0);
        checkOutput("t5_thr0", 32'(dataReq), 32'd0);

        // Enable drop discards partial half-word
        doClear();
        applyStimulus(1, 16'h1234, 0);
        en = 1'b0;
        applyStimulus(0, 16'h0, 0);
        en = 1'b1;
        applyStimulus(1, 16'hAAAA, 0);
        applyStimulus(1, 16'hBBBB, 0);
        checkOutput("t6_level", 32'(levelO), 32'd1);
        checkOutput("t6_word", rdData, 32'hBBBBAAAA);

        // Randomized traffic
        for (int p = 0; p < 6; p++) begin
            doClear();
            dec   = 16'($urandom_range(0, 4));
            thr   = 5'($urandom_range(0, 16));
            rdPct = 10 + 15 * p;
            for (int c = 0; c < 150; c++) begin
                en      = ($urandom_range(0, 19) != 0);
                valid   = $urandom_range(0, 1) == 1;
                adcData = 16'($urandom);
                rd      = ($urandom_range(0, 99) < rdPct);
                tick();
            end
            en = 1'b1; valid = 1'b0; rd = 1'b0;
        end

        // Asynchronous reset mid-transfer
        doClear();
        dec = 16'd1;
        thr = 5'd2;
        for (int i = 0; i < 6; i++) applyStimulus(1, 16'(i), 0);
        applyStimulus(0, 16'h0, 0);
        checkOutput("t7_pre_level", 32'(levelO), 32'd3);
        checkOutput("t7_pre_dreq", 32'(dataReq), 32'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_level", 32'(levelO), 32'd0);
        checkOutput("t7_rst_empty", 32'(emptyO), 32'd1);
        checkOutput("t7_rst_full", 32'(fullO), 32'd0);
        checkOutput("t7_rst_dreq", 32'(dataReq), 32'd0);
        checkOutput("t7_rst_ovf", 32'(overflow), 32'd0);
        modelReset();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        applyStimulus(1, 16'h5555, 0);
        applyStimulus(1, 16'h6666, 0);
        checkOutput("t7_after_word", rdData, 32'h66665555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
